// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: operand widths and architecturally named registers.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decoder_5x32.sv
// Write-side demultiplexer: one-hot select of the addressed register, all-zero when disabled.
module decoder_5x32
  import mips_pkg::*;
#(
  parameter int unsigned DEC_ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned DEC_NOUT   = mips_pkg::NREGS
) (
  input  logic                  we,
  input  logic [DEC_ADDR_W-1:0] wa,
  output logic [DEC_NOUT-1:0]   dec
);

  always_comb begin
    dec = '0;
    if (we) dec[wa] = 1'b1;
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 32x32 MIPS register file: two combinational read ports, one clocked write port, $0 reads zero.
// Build option REG_FILE_WR_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_32x32
  import mips_pkg::*;
#(
  parameter int unsigned RF_DATA_W = mips_pkg::DATA_W,
  parameter int unsigned RF_ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned RF_NREGS  = mips_pkg::NREGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [RF_ADDR_W-1:0] wa,
  input  logic [RF_DATA_W-1:0] wd,
  input  logic [RF_ADDR_W-1:0] ra1,
  input  logic [RF_ADDR_W-1:0] ra2,
  output logic [RF_DATA_W-1:0] rd1,
  output logic [RF_DATA_W-1:0] rd2
);

  logic [RF_NREGS-1:0]  dec;
  logic [RF_NREGS-1:0]  wr_sel;
  logic [RF_DATA_W-1:0] regs [RF_NREGS];

  decoder_5x32 #(
    .DEC_ADDR_W (RF_ADDR_W),
    .DEC_NOUT   (RF_NREGS)
  ) u_dec (
    .we  (we),
    .wa  (wa),
    .dec (dec)
  );

  // The decoder stays generic; $0 is masked out here so it can never load.
  assign wr_sel = dec & ~RF_NREGS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RF_NREGS); i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(RF_NREGS); i++) begin
        if (wr_sel[i]) regs[i] <= wd;
      end
    end
  end

  always_comb begin
    rd1 = (ra1 == RF_ADDR_W'(REG_ZERO)) ? '0 : regs[ra1];
    rd2 = (ra2 == RF_ADDR_W'(REG_ZERO)) ? '0 : regs[ra2];
`ifdef REG_FILE_WR_BYPASS_EN
    // WB-to-ID forwarding; storage still updates on the edge.
    if (we && (wa != RF_ADDR_W'(REG_ZERO))) begin
      if (ra1 == wa) rd1 = wd;
      if (ra2 == wa) rd2 = wd;
    end
`endif
  end

endmodule
